seq_bus_datapath: RTL

Parametrised single-bus CPU datapath with a built-in micro-sequencer that executes one register-transfer command at a time. Each command is issued over a valid/ready handshake. The sequencer drives the internal bus selects, Y/Z/HI/LO latching and register writes itself, so the surrounding control unit issues one command per instruction rather than one strobe per phase. The block adds configurable width and register count, and iterative multiply and divide.

---
 rtl/seq_bus_datapath_pkg.sv | 40 ++++
 rtl/seq_bus_datapath_if.sv | 32 +++
 rtl/seq_bus_datapath_muldiv_iter.sv | 94 +++++++++
 rtl/seq_bus_datapath.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/seq_bus_datapath_pkg.sv
// Shared types for the sequenced single-bus datapath: op codes, sequencer states
// and op-group decode helpers.
package datapath_pkg;

  typedef enum logic [3:0] {
    ADD  = 4'd0,
    SUB  = 4'd1,
    AND  = 4'd2,
    OR   = 4'd3,
    SHL  = 4'd4,
    SHR  = 4'd5,
    ADDI = 4'd6,
    MUL  = 4'd7,
    DIV  = 4'd8,
    MFHI = 4'd9,
    MFLO = 4'd10
  } op_t;

  typedef enum logic [2:0] {
    IDLE,
    T_Y,
    T_OP,
    T_ITER,
    T_WBLO,
    T_WBHI
  } state_t;

  function automatic logic is_alu(logic [3:0] op);
    return op <= 4'(ADDI);
  endfunction

  function automatic logic is_muldiv(logic [3:0] op);
    return (op == 4'(MUL)) || (op == 4'(DIV));
  endfunction

  function automatic logic is_mf(logic [3:0] op);
    return (op == 4'(MFHI)) || (op == 4'(MFLO));
  endfunction

endpackage

// File: rtl/seq_bus_datapath_if.sv
// Command handshake, status and debug/observation signals of seq_bus_datapath.
interface seq_bus_datapath_if #(
  parameter int WIDTH = 32,
  parameter int NREGS = 16,
  parameter int RW    = $clog2(NREGS)
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [3:0]       cmd_op;
  logic [RW-1:0]    cmd_ra;
  logic [RW-1:0]    cmd_rb;
  logic [RW-1:0]    cmd_rc;
  logic [WIDTH-1:0] cmd_imm;
  logic             done;
  logic             busy;
  logic             div_zero;
  logic             illegal;
  logic [RW-1:0]    dbg_sel;
  logic [WIDTH-1:0] dbg_data;
  logic [WIDTH-1:0] hi_out;
  logic [WIDTH-1:0] lo_out;

  modport master (
    output cmd_valid, cmd_op, cmd_ra, cmd_rb, cmd_rc, cmd_imm, dbg_sel,
    input  cmd_ready, done, busy, div_zero, illegal, dbg_data, hi_out, lo_out
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_ra, cmd_rb, cmd_rc, cmd_imm, dbg_sel,
    output cmd_ready, done, busy, div_zero, illegal, dbg_data, hi_out, lo_out
  );
endinterface

// File: rtl/seq_bus_datapath_muldiv_iter.sv
// Iterative unsigned multiply (shift-add) / restoring divide, one bit per cycle.
// Divide by zero resolves immediately at start: lo = all ones, hi = dividend.
module muldiv_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic             op_is_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_zero
);
  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, b_q, b_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d, div_q, div_d, dz_q, dz_d;
  logic [WIDTH:0]   mul_sum, div_shl;
  logic             div_ge;

  always_comb begin
    mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    div_shl = {hi_q, lo_q[WIDTH-1]};
    div_ge  = div_shl >= {1'b0, b_q};
  end

  always_comb begin
    hi_d   = hi_q;
    lo_d   = lo_q;
    b_d    = b_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    div_d  = div_q;
    dz_d   = dz_q;
    if (start) begin
      div_d = op_is_div;
      if (op_is_div && (b == '0)) begin
        hi_d   = a;
        lo_d   = '1;
        dz_d   = 1'b1;
        busy_d = 1'b0;
      end else begin
        hi_d   = '0;
        lo_d   = a;
        b_d    = b;
        cnt_d  = CW'(WIDTH);
        busy_d = 1'b1;
        dz_d   = 1'b0;
      end
    end else if (busy_q) begin
      if (div_q) begin
        // remainder shifts up through hi while quotient bits enter lo from the right
        hi_d = div_ge ? WIDTH'(div_shl - {1'b0, b_q}) : div_shl[WIDTH-1:0];
        lo_d = {lo_q[WIDTH-2:0], div_ge};
      end else begin
        hi_d = mul_sum[WIDTH:1];
        lo_d = {mul_sum[0], lo_q[WIDTH-1:1]};
      end
      cnt_d = cnt_q - CW'(1);
      if (cnt_q == CW'(1)) busy_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      hi_q   <= '0;
      lo_q   <= '0;
      b_q    <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      div_q  <= 1'b0;
      dz_q   <= 1'b0;
    end else begin
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      b_q    <= b_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      div_q  <= div_d;
      dz_q   <= dz_d;
    end
  end

  assign busy     = busy_q;
  assign done     = busy_q && (cnt_q == CW'(1));
  assign hi       = hi_q;
  assign lo       = lo_q;
  assign div_zero = dz_q;
endmodule

// File: rtl/seq_bus_datapath.sv
// Single-bus datapath with a micro-sequencer running one register-transfer
// command per handshake: register file, Y/Z/HI/LO, bus mux, ALU and muldiv.
module seq_bus_datapath
  import datapath_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int NREGS = 16,
  parameter int RW    = $clog2(NREGS)
) (
  input  logic              clock,
  input  logic              clear,
  seq_bus_datapath_if.slave io
);
  localparam int SW = $clog2(WIDTH);

  state_t             state_q, state_d;
  logic [3:0]         op_q, op_d;
  logic [RW-1:0]      ra_q, ra_d, rb_q, rb_d, rc_q, rc_d;
  logic [WIDTH-1:0]   imm_q, imm_d, y_q, y_d, hi_q, hi_d, lo_q, lo_d;
  logic [2*WIDTH-1:0] z_q, z_d, alu_z;
  logic [WIDTH-1:0]   regs_q [NREGS];
  logic [WIDTH-1:0]   regs_d [NREGS];
  logic               done_q, done_d, ready_q, ready_d;
  logic               dz_q, dz_d, ill_q, ill_d;
  logic [WIDTH-1:0]   bus_w, alu_lo;
  logic               accept, md_start, md_busy, md_done, md_dz;
  logic [WIDTH-1:0]   md_hi, md_lo;

  muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
    .clock    (clock),
    .clear    (clear),
    .start    (md_start),
    .op_is_div(op_q == 4'(DIV)),
    .a        (y_q),
    .b        (bus_w),
    .busy     (md_busy),
    .done     (md_done),
    .hi       (md_hi),
    .lo       (md_lo),
    .div_zero (md_dz)
  );

  always_comb begin
    bus_w = '0;
    case (state_q)
      T_Y:     bus_w = regs_q[rb_q];
      T_OP:    bus_w = (op_q == 4'(ADDI)) ? imm_q : regs_q[rc_q];
      default: bus_w = '0;
    endcase
  end

  always_comb begin
    alu_lo = '0;
    case (op_q)
      ADD, ADDI: alu_lo = y_q + bus_w;
      SUB:       alu_lo = y_q - bus_w;
      AND:       alu_lo = y_q & bus_w;
      OR:        alu_lo = y_q | bus_w;
      SHL:       alu_lo = y_q << bus_w[SW-1:0];
      SHR:       alu_lo = y_q >> bus_w[SW-1:0];
      default:   alu_lo = '0;
    endcase
    alu_z = {{WIDTH{1'b0}}, alu_lo};
  end

  assign accept = io.cmd_valid & ready_q;

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    ra_d     = ra_q;
    rb_d     = rb_q;
    rc_d     = rc_q;
    imm_d    = imm_q;
    y_d      = y_q;
    z_d      = z_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    regs_d   = regs_q;
    dz_d     = dz_q;
    ill_d    = ill_q;
    md_start = 1'b0;
    case (state_q)
      IDLE: if (accept) begin
        op_d    = io.cmd_op;
        ra_d    = io.cmd_ra;
        rb_d    = io.cmd_rb;
        rc_d    = io.cmd_rc;
        imm_d   = io.cmd_imm;
        dz_d    = 1'b0;
        ill_d   = !(is_alu(io.cmd_op) || is_muldiv(io.cmd_op) || is_mf(io.cmd_op));
        state_d = (is_alu(io.cmd_op) || is_muldiv(io.cmd_op)) ? T_Y : T_WBLO;
      end
      T_Y: begin
        y_d     = bus_w;
        state_d = T_OP;
      end
      T_OP: begin
        if (is_muldiv(op_q)) begin
          md_start = 1'b1;
          state_d  = ((op_q == 4'(DIV)) && (bus_w == '0)) ? T_WBLO : T_ITER;
        end else begin
          z_d     = alu_z;
          state_d = T_WBLO;
        end
      end
      T_ITER: if (md_done || !md_busy) state_d = T_WBLO;
      T_WBLO: begin
        state_d = IDLE;
        if (is_alu(op_q)) begin
          regs_d[ra_q] = z_q[WIDTH-1:0];
        end else if (is_muldiv(op_q)) begin
          // the iterator result is parked in Z so HI can follow one cycle later
          z_d     = {md_hi, md_lo};
          lo_d    = md_lo;
          dz_d    = md_dz;
          state_d = T_WBHI;
        end else if (op_q == 4'(MFHI)) begin
          regs_d[ra_q] = hi_q;
        end else if (op_q == 4'(MFLO)) begin
          regs_d[ra_q] = lo_q;
        end
      end
      T_WBHI: begin
        hi_d    = z_q[2*WIDTH-1:WIDTH];
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    done_d  = (state_d == T_WBHI) || ((state_d == T_WBLO) && !is_muldiv(op_d));
    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q <= IDLE;
      op_q    <= '0;
      ra_q    <= '0;
      rb_q    <= '0;
      rc_q    <= '0;
      imm_q   <= '0;
      y_q     <= '0;
      z_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      regs_q  <= '{default: '0};
      done_q  <= 1'b0;
      ready_q <= 1'b1;
      dz_q    <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      rc_q    <= rc_d;
      imm_q   <= imm_d;
      y_q     <= y_d;
      z_q     <= z_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      regs_q  <= regs_d;
      done_q  <= done_d;
      ready_q <= ready_d;
      dz_q    <= dz_d;
      ill_q   <= ill_d;
    end
  end

  assign io.cmd_ready = ready_q;
  assign io.busy      = ~ready_q;
  assign io.done      = done_q;
  assign io.div_zero  = dz_q;
  assign io.illegal   = ill_q;
  assign io.dbg_data  = regs_q[io.dbg_sel];
  assign io.hi_out    = hi_q;
  assign io.lo_out    = lo_q;
endmodule
